xif_result_commit_buffer: RTL

- Parametrised successor to the coprocessor-side XIF result path. Adds commit/kill tracking, which the current interface leaves commented out.
- Holds up to DEPTH accepted offloaded instructions, in issue order.
- Captures out-of-order FPU results by ID and releases results to the core result interface strictly in issue order, only after commit.
- Silently retires killed instructions and drops their results. Sits between the issue/commit front end and the FPU result path.

---
 rtl/xif_result_commit_buffer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/xif_result_commit_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xif_result_commit_buffer : in-order commit/kill tracker for offloaded FPU ops
// Revision: 1.0
// ---------------------------------------------------------------------------
module xif_result_commit_buffer #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [X_ID_WIDTH-1:0]  alloc_id,
    input  logic                   alloc_wb,
    input  logic                   commit_valid,
    input  logic [X_ID_WIDTH-1:0]  commit_id,
    input  logic                   commit_kill,
    input  logic                   fpu_valid,
    output logic                   fpu_ready,
    input  logic [X_ID_WIDTH-1:0]  fpu_id,
    input  logic [X_RFW_WIDTH-1:0] fpu_data,
    input  logic [4:0]             fpu_rd,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [X_ID_WIDTH-1:0]  result_id,
    output logic [X_RFW_WIDTH-1:0] result_data,
    output logic [4:0]             result_rd,
    output logic [CNT_W-1:0]       count,
    output logic                   err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_ISSUED    = 2'd1,
        ST_COMMITTED = 2'd2,
        ST_KILLED    = 2'd3
    } ent_state_e;

    ent_state_e             state_q   [DEPTH];
    ent_state_e             state_d   [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q      [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_d      [DEPTH];
    logic                   wb_q      [DEPTH];
    logic                   wb_d      [DEPTH];
    logic                   has_res_q [DEPTH];
    logic                   has_res_d [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q    [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_d    [DEPTH];
    logic [4:0]             rd_q      [DEPTH];
    logic [4:0]             rd_d      [DEPTH];

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   err_q, err_d;
    logic                   result_valid_q, result_valid_d;
    logic [X_ID_WIDTH-1:0]  result_id_q, result_id_d;
    logic [X_RFW_WIDTH-1:0] result_data_q, result_data_d;
    logic [4:0]             result_rd_q, result_rd_d;

    logic                   full;
    logic                   alloc_fire;
    logic                   retire;
    logic                   dup_id;
    logic                   commit_hit;
    logic                   fpu_hit;
    logic [PTR_W-1:0]       commit_idx;
    logic [PTR_W-1:0]       fpu_idx;
    logic [PTR_W-1:0]       idx;

    assign full        = (count_q >= CNT_W'(DEPTH));
    assign alloc_ready = ~full;
    assign fpu_ready   = ~reset;
    assign count       = count_q;
    assign err         = err_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign result_data  = result_data_q;
    assign result_rd    = result_rd_q;

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        wb_d           = wb_q;
        has_res_d      = has_res_q;
        data_d         = data_q;
        rd_d           = rd_q;
        head_d         = head_q;
        tail_d         = tail_q;
        err_d          = err_q;
        result_valid_d = result_valid_q;
        result_id_d    = result_id_q;
        result_data_d  = result_data_q;
        result_rd_d    = result_rd_q;
        alloc_fire     = 1'b0;
        retire         = 1'b0;
        dup_id         = 1'b0;
        commit_hit     = 1'b0;
        fpu_hit        = 1'b0;
        commit_idx     = '0;
        fpu_idx        = '0;
        idx            = '0;

        // Oldest-first scan so duplicate IDs resolve to the earliest issue.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (state_q[idx] != ST_FREE && id_q[idx] == alloc_id) begin
                dup_id = 1'b1;
            end
            if (!commit_hit && state_q[idx] == ST_ISSUED && id_q[idx] == commit_id) begin
                commit_hit = 1'b1;
                commit_idx = idx;
            end
            if (!fpu_hit && state_q[idx] != ST_FREE && wb_q[idx] && !has_res_q[idx]
                && id_q[idx] == fpu_id) begin
                fpu_hit = 1'b1;
                fpu_idx = idx;
            end
        end

        if (result_valid_q && result_ready) begin
            retire = 1'b1;
        end else if ((state_q[head_q] == ST_COMMITTED && !wb_q[head_q]) ||
                     (state_q[head_q] == ST_KILLED && (has_res_q[head_q] || !wb_q[head_q]))) begin
            retire = 1'b1;
        end
        if (retire) begin
            state_d[head_q]   = ST_FREE;
            has_res_d[head_q] = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end

        if (alloc_valid) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                alloc_fire        = 1'b1;
                state_d[tail_q]   = ST_ISSUED;
                id_d[tail_q]      = alloc_id;
                wb_d[tail_q]      = alloc_wb;
                has_res_d[tail_q] = 1'b0;
                tail_d            = tail_q + PTR_W'(1);
                if (dup_id) begin
                    err_d = 1'b1;
                end
            end
            if (commit_valid && commit_id == alloc_id) begin
                err_d = 1'b1;
            end
        end

        if (commit_valid && commit_hit) begin
            state_d[commit_idx] = commit_kill ? ST_KILLED : ST_COMMITTED;
        end

        if (fpu_valid && fpu_ready) begin
            if (fpu_hit) begin
                has_res_d[fpu_idx] = 1'b1;
                data_d[fpu_idx]    = fpu_data;
                rd_d[fpu_idx]      = fpu_rd;
            end else begin
                err_d = 1'b1;
            end
        end

        count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire);

        // Look at the post-update head so a result arriving this cycle is presented next cycle.
        if (!(result_valid_q && !result_ready)) begin
            result_valid_d = (state_d[head_d] == ST_COMMITTED) && wb_d[head_d] && has_res_d[head_d];
            if (result_valid_d) begin
                result_id_d   = id_d[head_d];
                result_data_d = data_d[head_d];
                result_rd_d   = rd_d[head_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i]   <= ST_FREE;
                id_q[i]      <= '0;
                wb_q[i]      <= 1'b0;
                has_res_q[i] <= 1'b0;
                data_q[i]    <= '0;
                rd_q[i]      <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            err_q          <= 1'b0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_data_q  <= '0;
            result_rd_q    <= '0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            wb_q           <= wb_d;
            has_res_q      <= has_res_d;
            data_q         <= data_d;
            rd_q           <= rd_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            err_q          <= err_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_data_q  <= result_data_d;
            result_rd_q    <= result_rd_d;
        end
    end

endmodule
`default_nettype wire
